// File: rtl/lru_age_tracker.sv
// -----------------------------------------------------------------------------
// lru_age_tracker
//   Keeps per-set, per-way LRU ages for the cache and serves them, flattened,
//   to the max-age victim selector. Each set's ages always form a permutation
//   of 0..NUM_WAY-1. Age NUM_WAY-1 marks the LRU way and age 0 the MRU way.
//   After reset, or after a flush, the INIT sweep writes age[i] = i into every
//   set. It takes one set per cycle. Accesses are held off during the sweep.
//
// Ports
//   clk_in               clock
//   reset_n_in           async active-low reset
//   flush_in             pulse: re-run the INIT sweep over all sets
//   access_valid_in      touch/invalidate request
//   access_ready_out     request accepted when valid & ready (high in IDLE)
//   access_set_in        target set
//   access_way_in        target way
//   access_invalidate_in 1: make way LRU, 0: make way MRU
//   read_valid_in        age read request
//   read_set_in          set to read
//   read_valid_out       way_flatted_out carries a fresh read this cycle
//   way_flatted_out      ages, way i at [i*W +: W]; holds when no read returns
//   index_error_out      sticky out-of-range access flag (checked build only)
//
// Configuration
//   LRU_AGE_TRACKER_CHECK_EN  defined: adds index_error_out. Out-of-range
//                             accesses are dropped in both builds.
//
// FSM states
//   state   | meaning
//   ST_INIT | sweep writing age[i]=i into set r_init_ptr, access not ready
//   ST_IDLE | accepting accesses and reads
// -----------------------------------------------------------------------------
module lru_age_tracker #(
    parameter int NUM_WAY                  = 16,
    parameter int NUM_SET                  = 16,
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int WAY_PTR_WIDTH_IN_BITS    = $clog2(NUM_WAY),
    parameter int SET_PTR_WIDTH_IN_BITS    = $clog2(NUM_SET)
) (
    input  logic                                        clk_in,
    input  logic                                        reset_n_in,
    input  logic                                        flush_in,
    input  logic                                        access_valid_in,
    output logic                                        access_ready_out,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]            access_set_in,
    input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]            access_way_in,
    input  logic                                        access_invalidate_in,
    input  logic                                        read_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]            read_set_in,
    output logic                                        read_valid_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_out
`ifdef LRU_AGE_TRACKER_CHECK_EN
    ,
    output logic                                        index_error_out
`endif
);

    localparam int W  = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int WP = WAY_PTR_WIDTH_IN_BITS;
    localparam int SP = SET_PTR_WIDTH_IN_BITS;

    // One extra bit so that the range compare works when NUM_SET or NUM_WAY
    // exactly fills the pointer width.
    localparam logic [WP:0]   WAY_LIMIT = (WP+1)'(NUM_WAY);
    localparam logic [SP:0]   SET_LIMIT = (SP+1)'(NUM_SET);
    localparam logic [SP-1:0] LAST_SET  = SP'(NUM_SET - 1);
    localparam logic [W-1:0]  LRU_AGE   = W'(NUM_WAY - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SP-1:0]          r_init_ptr;
    logic [W-1:0]           r_age [NUM_SET][NUM_WAY];
    logic                   r_read_valid;
    logic [W*NUM_WAY-1:0]   r_way_flat;

    logic                   w_access_fire;
    logic                   w_index_ok;
    logic                   w_access_wr;
    logic                   w_read_take;
    logic                   w_init_last;
    logic [SP-1:0]          w_acc_set_idx;
    logic [WP-1:0]          w_acc_way_idx;
    logic [W-1:0]           w_acc_old [NUM_WAY];
    logic [W-1:0]           w_acc_new [NUM_WAY];
    logic [W-1:0]           w_acc_age;
    logic [W*NUM_WAY-1:0]   w_rd_flat;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                // A flush during the sweep restarts it, so INIT is kept.
                if (!flush_in && w_init_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_in) begin
                    w_state_nxt = ST_INIT;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        access_ready_out = (r_state == ST_IDLE);
    end

    // ---------------- init sweep pointer ----------------
    assign w_init_last = (r_init_ptr == LAST_SET);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_init_ptr <= '0;
        end else if (flush_in || w_init_last) begin
            r_init_ptr <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
        end
    end

    // ---------------- access read-modify-write ----------------
    assign w_access_fire = access_valid_in & access_ready_out;
    assign w_index_ok    = ({1'b0, access_way_in} < WAY_LIMIT) &&
                           ({1'b0, access_set_in} < SET_LIMIT);
    assign w_access_wr   = w_access_fire & w_index_ok;

    // Out-of-range requests are never written. Their indices are clamped to 0
    // here so that the lookup below stays inside the array.
    assign w_acc_set_idx = w_index_ok ? access_set_in : '0;
    assign w_acc_way_idx = w_index_ok ? access_way_in : '0;

    always_comb begin
        for (int i = 0; i < NUM_WAY; i++) begin
            w_acc_old[i] = r_age[w_acc_set_idx][i];
        end
    end

    assign w_acc_age = w_acc_old[w_acc_way_idx];

    // Touch: ways younger than the target age by one and the target becomes 0.
    // Invalidate: ways older than the target get younger by one and the target
    // becomes LRU. Both preserve the permutation.
    always_comb begin
        for (int i = 0; i < NUM_WAY; i++) begin
            w_acc_new[i] = w_acc_old[i];
            if (WP'(i) == w_acc_way_idx) begin
                w_acc_new[i] = access_invalidate_in ? LRU_AGE : '0;
            end else if (!access_invalidate_in && (w_acc_old[i] < w_acc_age)) begin
                w_acc_new[i] = w_acc_old[i] + 1'b1;
            end else if (access_invalidate_in && (w_acc_old[i] > w_acc_age)) begin
                w_acc_new[i] = w_acc_old[i] - 1'b1;
            end
        end
    end

    // Age storage has no reset. The INIT sweep writes it before any use.
    always_ff @(posedge clk_in) begin
        if (r_state == ST_INIT) begin
            for (int i = 0; i < NUM_WAY; i++) begin
                r_age[r_init_ptr][i] <= W'(i);
            end
        end else if (w_access_wr) begin
            for (int i = 0; i < NUM_WAY; i++) begin
                r_age[w_acc_set_idx][i] <= w_acc_new[i];
            end
        end
    end

    // ---------------- read path ----------------
    // A read in the flush cycle is dropped, because its data would be
    // overwritten by the sweep that starts next.
    assign w_read_take = read_valid_in & (r_state == ST_IDLE) & ~flush_in;

    // Forward post-update ages when the same set is accessed in this cycle.
    always_comb begin
        w_rd_flat = '0;
        for (int i = 0; i < NUM_WAY; i++) begin
            if (w_access_wr && (access_set_in == read_set_in)) begin
                w_rd_flat[i*W +: W] = w_acc_new[i];
            end else begin
                w_rd_flat[i*W +: W] = r_age[read_set_in][i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_read_valid <= 1'b0;
            r_way_flat   <= '0;
        end else begin
            r_read_valid <= w_read_take;
            if (w_read_take) begin
                r_way_flat <= w_rd_flat;
            end
        end
    end

    assign read_valid_out  = r_read_valid;
    assign way_flatted_out = r_way_flat;

`ifdef LRU_AGE_TRACKER_CHECK_EN
    logic r_index_error;

    // Sticky until reset. A flush does not clear it.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_index_error <= 1'b0;
        end else if (w_access_fire && !w_index_ok) begin
            r_index_error <= 1'b1;
        end
    end

    assign index_error_out = r_index_error;
`endif

endmodule
